uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Parametrised successor to the FPGA-board program loader. It takes bytes from the board UART receiver, parses checksummed write frames, and drives the instruction-RAM write port with words of any byte-multiple width at any address width. Each frame gets an ACK or NAK byte back through the UART transmitter. It adds an inter-byte timeout, an error counter and a busy flag to the plain stream-to-memory loader. It sits between the UART byte receiver/transmitter and the IRAM write port (`iram_wa`/`iram_wen`/`iram_din`) in the board top level.

## Interface
- `DATA_W`, default 16: memory word width; must be a multiple of 8, 8..64. `WORD_BYTES = DATA_W/8`.
- `ADDR_W`, default 8: memory address width, 1..16. `ADDR_BYTES = ceil(ADDR_W/8)`.
- `TIMEOUT_CYC`, default 1_000_000: idle clk cycles allowed between bytes inside a frame.

Ports:
- `clk`  in  1  system clock. One clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `tx_data`  out  8  response byte; held stable from `tx_start` until the next response.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy`  in  1  transmitter busy; `tx_start` is issued only while this is low.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_din`  out  DATA_W  write data.
- `loading`  out  1  high while a frame is being parsed, from the cycle after SYNC through the response.
- `frame_ok`  out  1  one-cycle pulse when an ACK is issued.
- `err_cnt`  out  8  count of NAKs plus timeouts; saturates at 0xFF.

## Operation
- Frame format, all bytes in order:
  - `A5` (SYNC)
  - CMD
  - ADDR: `ADDR_BYTES` bytes, MSB first; only the low `ADDR_W` bits are kept.
  - N: word count, 0..255.
  - N words of `WORD_BYTES` bytes each, MSB first.
  - CSUM
- Checksum rule: the 8-bit sum of CMD through CSUM must equal 0x00. SYNC is excluded.
- CMD `57` ('W') is the only valid command.
- FSM states and transitions:
  - IDLE → CMD on `rx_valid` with `rx_data==A5`. All other bytes are ignored.
  - CMD: `57` → ADDR. Any other value → RESP(NAK).
  - ADDR → COUNT after `ADDR_BYTES` bytes.
  - COUNT: N=0 → CSUM; otherwise → DATA.
  - DATA: shifts bytes into the word register. On the last byte of each word, issue a write. After word N → CSUM.
  - CSUM: sum OK → RESP(ACK `06`); sum bad → RESP(NAK `15`).
  - RESP: wait for `tx_busy==0`, pulse `tx_start`, → IDLE. Bytes arriving in RESP are dropped.
- Writes are not buffered. Words written before a bad checksum stay in memory; the NAK tells the host to resend.
- Address auto-increments after each write and wraps modulo 2^ADDR_W.
- Timeout:
  - In CMD, ADDR, COUNT, DATA and CSUM, a counter clears on every `rx_valid`.
  - When it reaches `TIMEOUT_CYC`: go to IDLE, increment `err_cnt`, send no response, drop any partial word.
- `err_cnt` increments on every NAK and every timeout, and holds at 0xFF.
- `frame_ok` pulses in the same cycle as an ACK `tx_start`.

## Timing
- Reset values: `tx_data=00`, `tx_start=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, `loading=0`, `frame_ok=0`, `err_cnt=00`; FSM in IDLE.
- Write latency: `mem_we` pulses for 1 cycle, in the cycle after the `rx_valid` of a word's last byte. `mem_addr`/`mem_din` are valid in that cycle.
- Address update: `mem_addr` advances in the cycle after `mem_we`.
- Response latency: `tx_start` comes 1 cycle after the CSUM byte, or after the bad CMD byte, if `tx_busy` is low. Otherwise it comes the cycle after `tx_busy` falls.
- `loading` rises 1 cycle after SYNC and falls with `tx_start` or a timeout.
- A timeout fires exactly `TIMEOUT_CYC` cycles after the last accepted in-frame byte.
- `rst` mid-frame clears everything asynchronously. No write or response is issued after reset releases.
- Back-to-back `rx_valid` in consecutive cycles must be accepted with no byte lost.

## Test plan
- Basic write, DATA_W=16, ADDR_W=8. Send `A5 57 10 02 12 34 AB CD D9` →
  - `mem_we` ×2: `[10]=1234`, `[11]=ABCD`
  - `tx_data=06`, `frame_ok` pulses once, `err_cnt=00`.
- Address wrap. Send `A5 57 FF 02 00 01 00 02 A5` → writes `[FF]=0001` then `[00]=0002`; ACK `06`.
- Bad checksum. Send the basic-write frame with CSUM `D8` → both writes occur, `tx_data=15`, `err_cnt=01`, no `frame_ok`.
- Unknown command. Send `A5 33` → NAK `15` 1 cycle later, no writes, back in IDLE. A following valid frame is ACKed.
- Timeout and reset. Use TIMEOUT_CYC=100.
  - Send `A5 57 10`, then go silent → at cycle 100 `loading` falls, `err_cnt` increments, no `tx_start`.
  - Separately, assert `rst` after `A5 57 10 01 12` → no write, all outputs at reset values.
- Wide config: DATA_W=32, ADDR_W=12, and `tx_busy` held high for 50 cycles.
  - Send `A5 57 01 23 01 DE AD BE EF` followed by the correct CSUM.
  - Required: write `[123]=DEADBEEF`; `tx_start` waits for `tx_busy` to fall.

Source files
------------

// File: rtl/uart_frame_loader_if.sv
// Byte-stream, response and IRAM write-port signals of the frame loader.
// The host/board side uses the master modport and the loader uses the slave modport.
interface uart_frame_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              loading;
  logic              frame_ok;
  logic [7:0]        err_cnt;

  modport master (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start, mem_we, mem_addr, mem_din, loading, frame_ok, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start, mem_we, mem_addr, mem_din, loading, frame_ok, err_cnt
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses checksummed UART write frames into IRAM writes and answers each one with ACK/NAK.
// state | meaning
// IDLE  | hunting for SYNC (A5)
// CMD   | expecting the command byte
// ADDR  | collecting start address bytes, MSB first
// COUNT | expecting the word count
// DATA  | shifting word bytes, writing on each word's last byte
// CSUM  | expecting the checksum byte
// RESP  | response pending, waiting for the transmitter to go idle
module uart_frame_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  uart_frame_loader_if.slave bus
);
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
  // Loaded with TIMEOUT_CYC-2 so the return to IDLE is visible exactly TIMEOUT_CYC cycles after the byte.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 2);
  localparam logic [7:0] SYNC = 8'hA5, CMD_WR = 8'h57, ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic              addr_cnt_q, addr_cnt_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              frame_ok_q, frame_ok_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        err_q, err_d;

  logic       in_frame, send, err_inc;
  logic [7:0] send_byte, sum_in;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    addr_d     = mem_we_q ? addr_q + ADDR_W'(1) : addr_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_cnt_d = addr_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
    resp_d     = resp_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    frame_ok_d = 1'b0;
    mem_we_d   = 1'b0;
    send       = 1'b0;
    send_byte  = NAK;
    err_inc    = 1'b0;
    sum_in     = sum_q + bus.rx_data;
    in_frame   = state_q inside {S_CMD, S_ADDR, S_COUNT, S_DATA, S_CSUM};

    if (in_frame && bus.rx_valid) begin
      tmo_d = TMO_LOAD;
      sum_d = sum_in;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC) begin
          state_d    = S_CMD;
          sum_d      = 8'h00;
          tmo_d      = TMO_LOAD;
          addr_cnt_d = 1'b0;
          byte_cnt_d = 3'd0;
          word_d     = '0;
        end
      end
      S_CMD: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WR) state_d = S_ADDR;
          else send = 1'b1;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          addr_d     = (addr_q << 8) | ADDR_W'(bus.rx_data);
          addr_cnt_d = addr_cnt_q + 1'b1;
          if (addr_cnt_q == 1'(ADDR_BYTES - 1)) state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (bus.rx_valid) begin
          word_cnt_d = bus.rx_data;
          state_d    = (bus.rx_data == 8'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          word_d = (word_q << 8) | DATA_W'(bus.rx_data);
          if (byte_cnt_q == 3'(WORD_BYTES - 1)) begin
            byte_cnt_d = 3'd0;
            mem_we_d   = 1'b1;
            word_cnt_d = word_cnt_q - 8'd1;
            if (word_cnt_q == 8'd1) state_d = S_CSUM;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      S_CSUM: begin
        if (bus.rx_valid) begin
          send      = 1'b1;
          send_byte = (sum_in == 8'h00) ? ACK : NAK;
        end
      end
      S_RESP: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp_q;
          frame_ok_d = (resp_q == ACK);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (send) begin
      resp_d  = send_byte;
      err_inc = (send_byte == NAK);
      if (!bus.tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = send_byte;
        frame_ok_d = (send_byte == ACK);
        state_d    = S_IDLE;
      end else begin
        state_d = S_RESP;
      end
    end

    if (in_frame && !bus.rx_valid && tmo_q == '0) begin
      state_d    = S_IDLE;
      err_inc    = 1'b1;
      byte_cnt_d = 3'd0;
      word_d     = '0;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      addr_cnt_q <= 1'b0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      resp_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      frame_ok_q <= 1'b0;
      mem_we_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      resp_q     <= resp_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      frame_ok_q <= frame_ok_d;
      mem_we_q   <= mem_we_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.frame_ok = frame_ok_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = word_q;
  assign bus.loading  = (state_q != S_IDLE);
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Two loader configurations (16b/8b and 32b/12b) share one byte source; a frame-level
// model predicts writes, responses, their cycles and the error count.
module tb_uart_frame_loader;
  localparam int T = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_busy = 1'b0;
  logic sel = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_loader_if #(.DATA_W(16), .ADDR_W(8))  ifa ();
  uart_frame_loader_if #(.DATA_W(32), .ADDR_W(12)) ifb ();

  assign ifa.rx_data  = rx_data;
  assign ifa.rx_valid = rx_valid & ~sel;
  assign ifa.tx_busy  = tx_busy;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_valid = rx_valid & sel;
  assign ifb.tx_busy  = tx_busy;

  uart_frame_loader #(.DATA_W(16), .ADDR_W(8), .TIMEOUT_CYC(T)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uart_frame_loader #(.DATA_W(32), .ADDR_W(12), .TIMEOUT_CYC(T)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct { int dut; int cyc; logic [15:0] addr; logic [63:0] data; } wr_t;
  typedef struct { int dut; int cyc; logic [7:0] data; logic ok; } rs_t;

  wr_t wr_act[$], wr_exp[$];
  rs_t rs_act[$], rs_exp[$];
  wr_t mw;
  rs_t mr;
  int stray_ok = 0;
  int vectors = 0, miscompares = 0;
  int err_m[2] = '{0, 0};
  int last_cyc = 0;
  logic [63:0] wbuf [256];

  always @(negedge clk) begin
    if (ifa.mem_we) begin
      mw.dut = 0; mw.cyc = cyc; mw.addr = 16'(ifa.mem_addr); mw.data = 64'(ifa.mem_din);
      wr_act.push_back(mw);
    end
    if (ifb.mem_we) begin
      mw.dut = 1; mw.cyc = cyc; mw.addr = 16'(ifb.mem_addr); mw.data = 64'(ifb.mem_din);
      wr_act.push_back(mw);
    end
    if (ifa.tx_start) begin
      mr.dut = 0; mr.cyc = cyc; mr.data = ifa.tx_data; mr.ok = ifa.frame_ok;
      rs_act.push_back(mr);
    end
    if (ifb.tx_start) begin
      mr.dut = 1; mr.cyc = cyc; mr.data = ifb.tx_data; mr.ok = ifb.frame_ok;
      rs_act.push_back(mr);
    end
    if ((ifa.frame_ok && !ifa.tx_start) || (ifb.frame_ok && !ifb.tx_start)) stray_ok++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, ".a_ctl"}, {ifa.tx_data, ifa.tx_start, ifa.mem_we, ifa.frame_ok, ifa.loading, ifa.err_cnt, ifa.mem_addr}, 64'h0);
    check({tag, ".a_din"}, 64'(ifa.mem_din), 64'h0);
    check({tag, ".b_ctl"}, {ifb.tx_data, ifb.tx_start, ifb.mem_we, ifb.frame_ok, ifb.loading, ifb.err_cnt, ifb.mem_addr}, 64'h0);
    check({tag, ".b_din"}, 64'(ifb.mem_din), 64'h0);
  endtask

  function automatic void exp_resp(input int d, input int at, input logic ack);
    rs_t e;
    e.dut = d; e.cyc = at; e.data = ack ? 8'h06 : 8'h15; e.ok = ack;
    rs_exp.push_back(e);
    if (!ack && err_m[d] < 255) err_m[d]++;
  endfunction

  // Sends one frame for config d (0: 16b data/8b addr, 1: 32b data/12b addr) and records what must happen.
  task automatic frame(input int d, input logic [7:0] cmd, input logic [15:0] addr, input int n,
                       input bit bad_sum, input int gapmax);
    int wb, ab, aw;
    logic [7:0] s, b;
    logic [63:0] dmask;
    wr_t e;
    wb = d ? 4 : 2;
    ab = d ? 2 : 1;
    aw = d ? 12 : 8;
    dmask = d ? 64'hFFFF_FFFF : 64'hFFFF;
    s = 8'h00;
    sel = d[0];
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    put(8'hA5);
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    put(cmd);
    s += cmd;
    if (cmd != 8'h57) begin
      exp_resp(d, last_cyc + 1, 1'b0);
      return;
    end
    for (int i = ab - 1; i >= 0; i--) begin
      b = 8'(addr >> (8 * i));
      s += b;
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      put(b);
    end
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    put(8'(n));
    s += 8'(n);
    for (int w = 0; w < n; w++) begin
      for (int k = wb - 1; k >= 0; k--) begin
        b = 8'(wbuf[w] >> (8 * k));
        s += b;
        if (gapmax > 0) idle($urandom_range(0, gapmax));
        put(b);
      end
      e.dut = d; e.cyc = last_cyc + 1;
      e.addr = 16'((int'(addr) + w) % (1 << aw));
      e.data = wbuf[w] & dmask;
      wr_exp.push_back(e);
    end
    b = 8'h00 - s;
    if (bad_sum) b = b ^ 8'h01;
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    put(b);
    exp_resp(d, last_cyc + 1, !bad_sum);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".nwr"}, 64'(wr_act.size()), 64'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_act.size(); i++) begin
      check({tag, ".wr_cyc"}, 64'(wr_act[i].cyc * 2 + wr_act[i].dut), 64'(wr_exp[i].cyc * 2 + wr_exp[i].dut));
      check({tag, ".wr_addr"}, 64'(wr_act[i].addr), 64'(wr_exp[i].addr));
      check({tag, ".wr_data"}, wr_act[i].data, wr_exp[i].data);
    end
    check({tag, ".nresp"}, 64'(rs_act.size()), 64'(rs_exp.size()));
    for (int i = 0; i < rs_exp.size() && i < rs_act.size(); i++) begin
      check({tag, ".tx_cyc"}, 64'(rs_act[i].cyc * 2 + rs_act[i].dut), 64'(rs_exp[i].cyc * 2 + rs_exp[i].dut));
      check({tag, ".tx_data"}, 64'({rs_act[i].data, rs_act[i].ok}), 64'({rs_exp[i].data, rs_exp[i].ok}));
    end
    check({tag, ".err_a"}, 64'(ifa.err_cnt), 64'(err_m[0]));
    check({tag, ".err_b"}, 64'(ifb.err_cnt), 64'(err_m[1]));
    check({tag, ".stray_ok"}, 64'(stray_ok), 64'h0);
    check({tag, ".loading"}, {62'h0, ifa.loading, ifb.loading}, 64'h0);
    wr_act.delete(); wr_exp.delete(); rs_act.delete(); rs_exp.delete();
    stray_ok = 0;
  endtask

  initial begin
    int t, e, rel, b0, n, d;
    logic [7:0] cmd;

    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    rst = 1'b0;
    idle(2);

    wbuf[0] = 64'h1234; wbuf[1] = 64'hABCD;
    frame(0, 8'h57, 16'h10, 2, 1'b0, 0);
    idle(4);
    compare_all("basic");

    wbuf[0] = 64'h0001; wbuf[1] = 64'h0002;
    frame(0, 8'h57, 16'hFF, 2, 1'b0, 0);
    idle(4);
    compare_all("wrap");

    wbuf[0] = 64'h1234; wbuf[1] = 64'hABCD;
    frame(0, 8'h57, 16'h10, 2, 1'b1, 0);
    idle(4);
    compare_all("badsum");

    frame(0, 8'h33, 16'h0, 0, 1'b0, 0);
    idle(2);
    frame(0, 8'h57, 16'h10, 2, 1'b0, 0);
    idle(4);
    compare_all("badcmd");

    sel = 1'b0;
    put(8'hA5); put(8'h57); put(8'h10);
    t = last_cyc;
    e = err_m[0];
    idle(1);
    check("loading_up", 64'(ifa.loading), 64'h1);
    while (cyc < t + T - 1) idle(1);
    check("tmo_before", 64'(ifa.loading), 64'h1);
    idle(1);
    check("tmo_at", 64'(ifa.loading), 64'h0);
    check("tmo_err", 64'(ifa.err_cnt), 64'(e + 1));
    err_m[0] = e + 1;
    idle(3);
    compare_all("timeout");

    put(8'hA5); put(8'h57); put(8'h10); put(8'h01); put(8'h12);
    rst = 1'b1;
    #2;
    chk_rst("midrst");
    idle(2);
    rst = 1'b0;
    err_m = '{0, 0};
    idle(6);
    chk_rst("postrst");
    compare_all("midrst");

    tx_busy = 1'b1;
    b0 = cyc;
    wbuf[0] = 64'hDEADBEEF;
    frame(1, 8'h57, 16'h0123, 1, 1'b0, 0);
    while (cyc < b0 + 50) idle(1);
    tx_busy = 1'b0;
    rel = cyc;
    rs_exp[rs_exp.size() - 1].cyc = rel + 1;
    idle(4);
    compare_all("wide_busy");

    for (int f = 0; f < 40; f++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(0, 5);
      for (int w = 0; w < n; w++) wbuf[w] = {$urandom, $urandom};
      cmd = ($urandom_range(0, 7) == 0) ? 8'(8'h30 + $urandom_range(0, 15)) : 8'h57;
      frame(d, cmd, 16'($urandom), n, ($urandom_range(0, 3) == 0), 2);
      idle(3);
      compare_all("rand");
    end

    sel = 1'b0;
    for (int i = 0; i < 260; i++) begin
      put(8'hA5);
      put(8'h33);
      idle(1);
    end
    idle(2);
    rs_act.delete();
    err_m[0] = 255;
    compare_all("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
